// File: rtl/atm_session_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : atm_session_ctrl
// Purpose  : ATM card session controller. Accepts one user command at a time,
//            validates it locally, runs a req/ack transaction with the account
//            store, reports a one-cycle response and locks on repeated failures.
// Revision : 1.0 - initial release
// ============================================================================
module atm_session_ctrl #(
  parameter int unsigned NUM_ACC  = 15,
  parameter int unsigned TIMEOUT  = 16,
  parameter int unsigned MAX_FAIL = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        card_valid,
  input  logic [3:0]  card_acc,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [9:0]  cmd_amount,
  input  logic [3:0]  cmd_purpose,
  output logic        bank_req,
  output logic [1:0]  bank_select,
  output logic [3:0]  bank_origin,
  output logic [3:0]  bank_purpose,
  output logic [9:0]  bank_amount,
  input  logic        bank_ack,
  input  logic [1:0]  bank_result,
  input  logic [9:0]  bank_inventory,
  output logic        rsp_valid,
  output logic [2:0]  rsp_status,
  output logic [9:0]  rsp_balance,
  output logic        locked,
  output logic [7:0]  txn_count
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam int unsigned FW = $clog2(MAX_FAIL + 1);

  localparam logic [2:0] c_st_ok      = 3'd0;
  localparam logic [2:0] c_st_short   = 3'd1;
  localparam logic [2:0] c_st_invalid = 3'd2;
  localparam logic [2:0] c_st_timeout = 3'd3;
  localparam logic [2:0] c_st_locked  = 3'd4;

  localparam logic [1:0] c_op_none     = 2'd0;
  localparam logic [1:0] c_op_inquiry  = 2'd1;
  localparam logic [1:0] c_op_withdraw = 2'd2;
  localparam logic [1:0] c_op_transfer = 2'd3;

  localparam logic [1:0] c_res_none    = 2'd0;
  localparam logic [1:0] c_res_success = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_READY  = 3'd1,
    ST_CHECK  = 3'd2,
    ST_REQ    = 3'd3,
    ST_RESP   = 3'd4,
    ST_LOCKED = 3'd5
  } state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [3:0]      r_card;
  logic [1:0]      r_op;
  logic [9:0]      r_amount;
  logic [3:0]      r_purpose;
  logic [2:0]      r_status;
  logic [9:0]      r_balance;
  logic [TW-1:0]   r_timer;
  logic [FW-1:0]   r_fail;
  logic [FW-1:0]   w_fail_next;
  logic [7:0]      r_txn;
  logic            r_lock_rsp;
  logic            w_invalid;
  logic            w_timer_done;

  assign w_timer_done = (r_timer == TW'(TIMEOUT - 1));

  // Local validation of the latched command against the latched card.
  always_comb begin
    w_invalid = 1'b0;
    if (r_op == c_op_none)
      w_invalid = 1'b1;
    if (32'(r_card) >= NUM_ACC)
      w_invalid = 1'b1;
    if ((r_op == c_op_withdraw || r_op == c_op_transfer) && r_amount == 10'd0)
      w_invalid = 1'b1;
    if (r_op == c_op_transfer && (32'(r_purpose) >= NUM_ACC || r_purpose == r_card))
      w_invalid = 1'b1;
  end

  // Saturating failure count as it will be after the current response.
  always_comb begin
    w_fail_next = r_fail;
    if (r_status == c_st_ok)
      w_fail_next = '0;
    else if (r_fail != FW'(MAX_FAIL))
      w_fail_next = r_fail + 1'b1;
  end

  always_comb begin
    w_state_next = r_state;
    cmd_ready    = 1'b0;
    bank_req     = 1'b0;
    locked       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (card_valid)
          w_state_next = ST_READY;
      end
      ST_READY: begin
        cmd_ready = 1'b1;
        if (cmd_valid)
          w_state_next = ST_CHECK;
        else if (!card_valid)
          w_state_next = ST_IDLE;
      end
      ST_CHECK: begin
        w_state_next = w_invalid ? ST_RESP : ST_REQ;
      end
      ST_REQ: begin
        bank_req = 1'b1;
        if (bank_ack || w_timer_done)
          w_state_next = ST_RESP;
      end
      ST_RESP: begin
        if (w_fail_next == FW'(MAX_FAIL))
          w_state_next = ST_LOCKED;
        else if (!card_valid)
          w_state_next = ST_IDLE;
        else
          w_state_next = ST_READY;
      end
      ST_LOCKED: begin
        locked    = 1'b1;
        cmd_ready = 1'b1;
        if (!card_valid)
          w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_card     <= '0;
      r_op       <= '0;
      r_amount   <= '0;
      r_purpose  <= '0;
      r_status   <= '0;
      r_balance  <= '0;
      r_timer    <= '0;
      r_fail     <= '0;
      r_txn      <= '0;
      r_lock_rsp <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_lock_rsp <= (r_state == ST_LOCKED) && cmd_valid;
      case (r_state)
        ST_IDLE: begin
          if (card_valid) begin
            r_card <= card_acc;
            r_fail <= '0;
          end
        end
        ST_READY: begin
          if (cmd_valid) begin
            r_op      <= cmd_op;
            r_amount  <= cmd_amount;
            r_purpose <= cmd_purpose;
          end
        end
        ST_CHECK: begin
          r_timer   <= '0;
          r_balance <= '0;
          if (w_invalid)
            r_status <= c_st_invalid;
        end
        ST_REQ: begin
          // An ack in the last allowed cycle wins over the timeout.
          if (bank_ack) begin
            if (bank_result == c_res_success) begin
              r_status  <= c_st_ok;
              r_txn     <= r_txn + 8'd1;
              r_balance <= (r_op == c_op_inquiry) ? bank_inventory : 10'd0;
            end else if (bank_result == c_res_none) begin
              r_status <= c_st_invalid;
            end else begin
              r_status <= c_st_short;
            end
          end else if (w_timer_done) begin
            r_status <= c_st_timeout;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        ST_RESP: begin
          r_fail <= w_fail_next;
        end
        default: ;
      endcase
    end
  end

  assign bank_select  = (r_state == ST_REQ) ? r_op      : 2'd0;
  assign bank_purpose = (r_state == ST_REQ) ? r_purpose : 4'd0;
  assign bank_amount  = (r_state == ST_REQ) ? r_amount  : 10'd0;
  assign bank_origin  = r_card;
  assign rsp_valid    = (r_state == ST_RESP) || r_lock_rsp;
  assign rsp_status   = r_lock_rsp ? c_st_locked :
                        (r_state == ST_RESP) ? r_status : 3'd0;
  assign rsp_balance  = (r_state == ST_RESP) ? r_balance : 10'd0;
  assign txn_count    = r_txn;

endmodule
`default_nettype wire

// File: tb/tb_atm_session_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_atm_session_ctrl
// Purpose  : Directed and randomized session scenarios for atm_session_ctrl,
//            checked against a rule-level model of the session.
// Revision : 1.0 - initial release
// ============================================================================
module tb_atm_session_ctrl;

  localparam int NUM_ACC  = 15;
  localparam int TIMEOUT  = 16;
  localparam int MAX_FAIL = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        card_valid = 1'b0;
  logic [3:0]  card_acc = '0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = '0;
  logic [9:0]  cmd_amount = '0;
  logic [3:0]  cmd_purpose = '0;
  logic        bank_req;
  logic [1:0]  bank_select;
  logic [3:0]  bank_origin;
  logic [3:0]  bank_purpose;
  logic [9:0]  bank_amount;
  logic        bank_ack = 1'b0;
  logic [1:0]  bank_result = '0;
  logic [9:0]  bank_inventory = '0;
  logic        rsp_valid;
  logic [2:0]  rsp_status;
  logic [9:0]  rsp_balance;
  logic        locked;
  logic [7:0]  txn_count;

  always #5 clk = ~clk;

  atm_session_ctrl #(.NUM_ACC(NUM_ACC), .TIMEOUT(TIMEOUT), .MAX_FAIL(MAX_FAIL)) dut (
    .clk(clk), .rst(rst), .card_valid(card_valid), .card_acc(card_acc),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_amount(cmd_amount), .cmd_purpose(cmd_purpose), .bank_req(bank_req),
    .bank_select(bank_select), .bank_origin(bank_origin), .bank_purpose(bank_purpose),
    .bank_amount(bank_amount), .bank_ack(bank_ack), .bank_result(bank_result),
    .bank_inventory(bank_inventory), .rsp_valid(rsp_valid), .rsp_status(rsp_status),
    .rsp_balance(rsp_balance), .locked(locked), .txn_count(txn_count)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Session model: card, failure streak, completed transactions, mode.
  int m_card = 0;
  int m_fail = 0;
  int m_txn  = 0;
  bit m_locked = 1'b0;
  bit m_idle   = 1'b1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] all_outs();
    return 64'({cmd_ready, bank_req, bank_select, bank_origin, bank_purpose, bank_amount,
                rsp_valid, rsp_status, rsp_balance, locked, txn_count});
  endfunction

  task automatic insert_card(input int acc);
    card_acc   = 4'(acc);
    card_valid = 1'b1;
    tick();
    check("insert_ready", 64'(cmd_ready), 64'(1));
    check("insert_origin", 64'(bank_origin), 64'(acc));
    m_card = acc; m_fail = 0; m_idle = 1'b0; m_locked = 1'b0;
  endtask

  task automatic remove_card();
    card_valid = 1'b0;
    tick();
    check("remove_idle", 64'({cmd_ready, locked}), 64'(0));
    m_idle = 1'b1; m_locked = 1'b0;
  endtask

  // d: index of the bank_req cycle carrying the ack; d<0 never acks,
  // d>=TIMEOUT acks only after the request has dropped.
  task automatic do_cmd(input int op, input int amt, input int purp, input int d,
                        input int res, input int inv, input bit drop);
    bit invalid, acked, late;
    int st, bal, exp_req, k, txn_before;
    cmd_op = 2'(op); cmd_amount = 10'(amt); cmd_purpose = 4'(purp); cmd_valid = 1'b1;
    check("cmd_ready", 64'(cmd_ready), 64'(1));
    tick();
    cmd_valid = 1'b0;
    cmd_op = 2'($urandom); cmd_amount = 10'($urandom); cmd_purpose = 4'($urandom);
    if (m_locked) begin
      check("locked_rsp", 64'({rsp_valid, rsp_status, bank_req}), 64'({1'b1, 3'd4, 1'b0}));
      tick();
      check("locked_rsp_end", 64'({rsp_valid, bank_req, locked}), 64'({1'b0, 1'b0, 1'b1}));
      return;
    end
    check("check_cycle", 64'({rsp_valid, bank_req, cmd_ready, bank_select, bank_purpose, bank_amount}), 64'(0));
    if (drop) card_valid = 1'b0;

    invalid = (op == 0) || (m_card >= NUM_ACC) || (op >= 2 && amt == 0) ||
              (op == 3 && (purp >= NUM_ACC || purp == m_card));
    if (invalid)                  st = 2;
    else if (d < 0 || d >= TIMEOUT) st = 3;
    else if (res == 3)            st = 0;
    else if (res == 0)            st = 2;
    else                          st = 1;
    bal = (st == 0 && op == 1) ? inv : 0;
    exp_req = (d >= 0 && d < TIMEOUT) ? d + 1 : TIMEOUT;

    tick();
    k = 0; acked = 1'b0;
    if (!invalid) begin
      while (bank_req && k < TIMEOUT + 2) begin
        check("bank_fields", 64'({bank_select, bank_origin, bank_purpose, bank_amount}),
              64'({2'(op), 4'(m_card), 4'(purp), 10'(amt)}));
        if (k == d) begin
          bank_ack = 1'b1; bank_result = 2'(res); bank_inventory = 10'(inv); acked = 1'b1;
        end else begin
          bank_ack = 1'b0; bank_result = 2'($urandom); bank_inventory = 10'($urandom);
        end
        tick();
        bank_ack = 1'b0;
        k++;
      end
      check("req_cycles", 64'(k), 64'(exp_req));
    end else begin
      check("no_bank_req", 64'(bank_req), 64'(0));
    end

    check("rsp", 64'({rsp_valid, rsp_status, rsp_balance}), 64'({1'b1, 3'(st), 10'(bal)}));
    if (st == 0) begin
      m_fail = 0;
      m_txn = (m_txn + 1) % 256;
    end else if (m_fail < MAX_FAIL) begin
      m_fail++;
    end
    check("txn_count", 64'(txn_count), 64'(m_txn));
    check("rsp_bank_idle", 64'({bank_select, bank_purpose, bank_amount}), 64'(0));

    late = !invalid && !acked && d >= 0;
    txn_before = m_txn;
    if (late) begin
      bank_ack = 1'b1; bank_result = 2'd3; bank_inventory = 10'(inv);
    end
    tick();
    bank_ack = 1'b0;
    check("post_rsp", 64'({rsp_valid, bank_req}), 64'(0));
    if (late) check("late_ack_txn", 64'(txn_count), 64'(txn_before));
    m_locked = (m_fail == MAX_FAIL);
    m_idle   = !m_locked && drop;
    check("post_state", 64'({locked, cmd_ready}), 64'({m_locked, !m_idle}));
  endtask

  initial begin
    int op, amt, purp, d, res;
    tick(); tick(); tick();
    check("reset_outs", all_outs(), 64'(0));
    rst = 1'b0;
    tick();
    check("idle_no_card", all_outs(), 64'(0));

    insert_card(5);
    do_cmd(1, 0, 0, 1, 3, 100, 1'b0);
    do_cmd(2, 150, 0, 0, 1, 7, 1'b0);
    do_cmd(2, 40, 0, 3, 3, 60, 1'b0);
    do_cmd(3, 10, 5, 2, 3, 0, 1'b0);
    do_cmd(3, 10, 3, 2, 3, 0, 1'b0);
    do_cmd(2, 0, 0, 0, 3, 0, 1'b0);
    remove_card();
    insert_card(15);
    do_cmd(1, 0, 0, 0, 3, 9, 1'b0);
    remove_card();
    insert_card(5);
    do_cmd(1, 0, 0, -1, 3, 9, 1'b0);
    do_cmd(1, 0, 0, TIMEOUT, 3, 9, 1'b0);
    do_cmd(1, 0, 0, TIMEOUT - 1, 3, 321, 1'b0);
    for (int i = 0; i < 3; i++) do_cmd(2, 500, 0, 1, 1, 0, 1'b0);
    do_cmd(1, 0, 0, 0, 3, 50, 1'b0);
    do_cmd(2, 10, 0, 0, 3, 50, 1'b0);
    remove_card();
    insert_card(5);
    do_cmd(1, 0, 0, 2, 3, 77, 1'b1);
    insert_card(5);

    // Reset in the middle of a bank request.
    cmd_op = 2'd1; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    tick();
    check("mid_req_active", 64'(bank_req), 64'(1));
    rst = 1'b1;
    tick();
    check("mid_req_reset", all_outs(), 64'(0));
    rst = 1'b0;
    m_txn = 0; m_fail = 0; m_idle = 1'b1; m_locked = 1'b0;
    insert_card(5);

    for (int i = 0; i < 60; i++) begin
      if (m_idle) insert_card(($urandom_range(0, 5) == 0) ? 15 : int'($urandom_range(0, 14)));
      else if ($urandom_range(0, 9) == 0 || (m_locked && $urandom_range(0, 2) == 0)) begin
        remove_card();
        insert_card(int'($urandom_range(0, 15)));
      end
      op   = int'($urandom_range(0, 3));
      amt  = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 1023));
      purp = int'($urandom_range(0, 15));
      d    = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, TIMEOUT));
      res  = int'($urandom_range(0, 3));
      do_cmd(op, amt, purp, d, res, int'($urandom_range(0, 1023)), $urandom_range(0, 11) == 0);
      if (m_idle == 1'b0 && card_valid == 1'b0) remove_card();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/atm_session_ctrl.md
# atm_session_ctrl

Initiator-side session controller for the ATM account store. It latches the inserted card's account and accepts one user command at a time over a valid/ready handshake. Each command is checked locally, then issued to the account-store core as a select/amount/origin/purpose request with a req/ack handshake. The controller captures the returned result code and balance, reports a one-cycle response, counts completed transactions and locks the session after repeated failures.

## Interface
- NUM_ACC, 15: valid account numbers are 0..NUM_ACC-1.
- TIMEOUT, 16: maximum cycles bank_req may wait for bank_ack.
- MAX_FAIL, 3: consecutive failed commands that lock the session.
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- card_valid  in  1  card present; a rising level starts a session.
- card_acc  in  4  card account number; sampled once on insertion.
- cmd_valid  in  1  user command offered.
- cmd_ready  out  1  controller can accept a command.
- cmd_op  in  2  0 none, 1 balance inquiry, 2 withdraw, 3 transfer.
- cmd_amount  in  10  withdraw/transfer amount, unsigned.
- cmd_purpose  in  4  destination account for a transfer.
- bank_req  out  1  request to the account store.
- bank_select  out  2  equals the latched cmd_op.
- bank_origin  out  4  latched card account.
- bank_purpose  out  4  latched cmd_purpose.
- bank_amount  out  10  latched cmd_amount.
- bank_ack  in  1  account store done; bank_result and bank_inventory are valid in this cycle.
- bank_result  in  2  3 success, 1 withdraw short, 2 transfer short, 0 none.
- bank_inventory  in  10  origin balance (valid for an inquiry).
- rsp_valid  out  1  one-cycle response strobe.
- rsp_status  out  3  0 OK, 1 insufficient funds, 2 invalid request, 3 timeout, 4 locked.
- rsp_balance  out  10  balance for an OK inquiry, else 0.
- locked  out  1  session locked.
- txn_count  out  8  successful bank transactions, wraps 255->0.

## Operation
- States: IDLE, READY, CHECK, REQ, RESP, LOCKED.
- IDLE: cmd_ready=0. When card_valid=1, latch card_acc, clear the fail counter and go to READY.
- READY: cmd_ready=1. A command is accepted on cmd_valid&&cmd_ready; cmd_op, cmd_amount and cmd_purpose are latched and the state goes to CHECK. If card_valid=0 and no command is accepted, go to IDLE.
- CHECK: the request is invalid if any of the following holds:
  - op=0;
  - card account >= NUM_ACC;
  - op 2/3 with amount=0;
  - op 3 with purpose >= NUM_ACC;
  - op 3 with purpose == origin.
  An invalid request goes to RESP with status 2 and no bank access. Otherwise go to REQ.
- REQ: bank_req=1 and all bank_* fields held stable until bank_ack is sampled high.
  - On ack with result 3: status 0 and txn_count+1. For op 1, rsp_balance=bank_inventory.
  - On ack with result 1 or 2: status 1.
  - On ack with result 0: status 2.
  - If no ack arrives within TIMEOUT cycles of bank_req rising: drop bank_req and set status 3.
- RESP: rsp_valid=1 for exactly one cycle.
  - Status 0 clears the fail counter. Statuses 1/2/3 increment it.
  - If the fail counter reaches MAX_FAIL, go to LOCKED. Else if card_valid=0, go to IDLE. Else go to READY.
- LOCKED: locked=1 and cmd_ready=1. Every accepted command gets rsp_valid the next cycle with status 4, and no bank access. When card_valid=0, go to IDLE and clear locked.
- Card removal during CHECK/REQ does not abort. The bank handshake completes, the response is issued, then the state goes to IDLE.
- cmd_valid while cmd_ready=0 is ignored; no queuing.
- bank_select, bank_purpose and bank_amount are 0 outside REQ.
- The fail counter saturates at MAX_FAIL.

## Timing
- Reset: state IDLE, and every output is 0 (cmd_ready, bank_req, bank_select, bank_origin, bank_purpose, bank_amount, rsp_valid, rsp_status, rsp_balance, locked, txn_count). rst overrides everything, including mid-REQ; bank_req drops the cycle after rst.
- Command accepted at edge T, then CHECK is cycle T+1.
  - Invalid request: rsp_valid in cycle T+2.
  - Valid request: bank_req high from cycle T+2.
- If bank_ack is high in cycle A: bank_req is low in A+1, and rsp_valid is high in A+1.
- Minimum bank latency is an ack in the first bank_req cycle, giving rsp_valid at T+3.
- Timeout: bank_req high for cycles R..R+TIMEOUT-1 with no ack, then rsp_valid with status 3 in R+TIMEOUT.
  - An ack in R+TIMEOUT-1 is honoured.
  - An ack after bank_req has dropped is ignored.
- cmd_ready is low in CHECK, REQ and RESP. The earliest next command is accepted in the cycle after RESP.
- LOCKED: a command accepted at edge T gets rsp_valid (status 4) in T+1.

## Test plan
- Reset, card_acc=5, then inquiry; bank acks in 2 cycles with result 3, inventory 100. Required: rsp_status 0, rsp_balance 100, txn_count 1, bank_select 1, bank_origin 5.
- Withdraw 150 from account 5; bank returns result 1. Required: status 1, txn_count unchanged. Then withdraw 40 returning result 3: status 0 and fail counter cleared.
- Transfer with purpose=5 from origin 5, and separately card_acc=15. Required: status 2 at T+2 and bank_req never asserted.
- Bank never acks, TIMEOUT=16. Required: bank_req high exactly 16 cycles, then status 3. A late ack injected afterwards has no effect.
- Three consecutive status-1 responses. Required: locked=1. The next inquiry gets status 4 at T+1 with no bank_req. Dropping card_valid returns to IDLE with locked=0.
- card_valid dropped during REQ: the bank handshake completes, rsp_valid is issued, then the state goes to IDLE. Also assert rst mid-REQ: all outputs are 0 the next cycle.
